// File: rtl/l1c_mem_arbiter.sv
// ---------------------------------------------------------------------------
// l1c_mem_arbiter
// Shares the single CPU-wrapper memory port between the instruction L1 cache
// (read-only) and the data L1 cache (read/write). One transaction is granted
// at a time, round-robin on ties. The winner's command is latched at grant
// and driven to the memory port until its final beat. Wait/data responses
// are routed only to the owning requester.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   i_rreq/i_addr/i_single        I-cache read request, address, single flag
//   i_out/i_wait                  I-cache read data, beat-complete strobe (low)
//   d_rreq/d_wreq/d_addr/d_in/d_type/d_single   D-cache command
//   d_out/d_wait                  D-cache read data, beat-complete strobe (low)
//   m_rreq/m_wreq/m_addr/m_in/m_type/m_single   command to memory wrapper
//   m_out/m_wait                  memory read data, beat-complete (low)
//   busy_o, owner_o               transaction in flight, owner (0=I, 1=D)
// ---------------------------------------------------------------------------
module l1c_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TYPE_W    = 3,
  parameter int BURST_LEN = 4,
  parameter bit D_FIRST   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_rreq,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_single,
  output logic [DATA_W-1:0] i_out,
  output logic              i_wait,
  // D-cache side
  input  logic              d_rreq,
  input  logic              d_wreq,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic [TYPE_W-1:0] d_type,
  input  logic              d_single,
  output logic [DATA_W-1:0] d_out,
  output logic              d_wait,
  // memory port
  output logic              m_rreq,
  output logic              m_wreq,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_in,
  output logic [TYPE_W-1:0] m_type,
  output logic              m_single,
  input  logic [DATA_W-1:0] m_out,
  input  logic              m_wait,
  // status
  output logic              busy_o,
  output logic              owner_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OFFS_W = $clog2(BURST_LEN * DATA_W / 8);
  localparam logic [TYPE_W-1:0] TYPE_WORD = TYPE_W'(2);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

  // Line fills start on a line boundary: clear the byte offset within a line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] mask;
    mask = {ADDR_W{1'b1}} << OFFS_W;
    return addr & mask;
  endfunction

  state_t              state_r;
  logic                last_owner_r;   // 0 = I side, 1 = D side
  logic [CNT_W-1:0]    beat_cnt_r;
  logic                rreq_r;
  logic                wreq_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   data_r;
  logic [TYPE_W-1:0]   type_r;
  logic                single_r;
  logic                busy_r;
  logic                owner_r;

  logic                i_req_s;
  logic                d_req_s;
  logic                pick_d_s;
  logic                final_beat_s;

  // Request decode, round-robin pick and final-beat detection.
  always_comb begin
    i_req_s      = i_rreq;
    d_req_s      = d_rreq | d_wreq;
    // D wins when it is the only requester, or on a tie when I owned last.
    pick_d_s     = d_req_s & (~i_req_s | ~last_owner_r);
    final_beat_s = ~m_wait & (single_r | (beat_cnt_r == LAST_BEAT));
  end

  // Arbiter FSM: grant, command latching, beat counting and release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_owner_r <= ~D_FIRST;
      beat_cnt_r   <= {CNT_W{1'b0}};
      rreq_r       <= 1'b0;
      wreq_r       <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      data_r       <= {DATA_W{1'b0}};
      type_r       <= {TYPE_W{1'b0}};
      single_r     <= 1'b0;
      busy_r       <= 1'b0;
      owner_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          beat_cnt_r <= {CNT_W{1'b0}};
          if (i_req_s | d_req_s) begin
            busy_r <= 1'b1;
            if (pick_d_s) begin
              state_r  <= GNT_D;
              owner_r  <= 1'b1;
              // A write beats a simultaneous read; writes are always single.
              rreq_r   <= ~d_wreq;
              wreq_r   <= d_wreq;
              single_r <= d_wreq | d_single;
              addr_r   <= (d_wreq | d_single) ? d_addr : line_align(d_addr);
              data_r   <= d_in;
              type_r   <= d_wreq ? d_type : TYPE_WORD;
            end else begin
              state_r  <= GNT_I;
              owner_r  <= 1'b0;
              rreq_r   <= 1'b1;
              wreq_r   <= 1'b0;
              single_r <= i_single;
              addr_r   <= i_single ? i_addr : line_align(i_addr);
              data_r   <= {DATA_W{1'b0}};
              type_r   <= TYPE_WORD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        GNT_I, GNT_D: begin
          if (final_beat_s) begin
            // Release: outputs return to their idle values for the mandatory
            // idle cycle, and the finishing side loses the next tie.
            state_r      <= IDLE;
            last_owner_r <= (state_r == GNT_D);
            beat_cnt_r   <= {CNT_W{1'b0}};
            rreq_r       <= 1'b0;
            wreq_r       <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            data_r       <= {DATA_W{1'b0}};
            type_r       <= {TYPE_W{1'b0}};
            single_r     <= 1'b0;
            busy_r       <= 1'b0;
            owner_r      <= 1'b0;
          end else if (!m_wait) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          beat_cnt_r <= {CNT_W{1'b0}};
          rreq_r     <= 1'b0;
          wreq_r     <= 1'b0;
          busy_r     <= 1'b0;
          owner_r    <= 1'b0;
        end
      endcase
    end
  end

  assign m_rreq   = rreq_r;
  assign m_wreq   = wreq_r;
  assign m_addr   = addr_r;
  assign m_in     = data_r;
  assign m_type   = type_r;
  assign m_single = single_r;
  assign busy_o   = busy_r;
  assign owner_o  = owner_r;

  // Response routing: only the owner sees memory wait/data.
  always_comb begin
    i_wait = 1'b1;
    i_out  = {DATA_W{1'b0}};
    d_wait = 1'b1;
    d_out  = {DATA_W{1'b0}};
    if (state_r == GNT_I) begin
      i_wait = m_wait;
      i_out  = m_out;
    end else if (state_r == GNT_D) begin
      d_wait = m_wait;
      d_out  = m_out;
    end else begin
      i_wait = 1'b1;
      d_wait = 1'b1;
    end
  end

endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l1c_mem_arbiter
// Directed bench for l1c_mem_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are checked one further unit later, well clear of the
// next edge. Memory responses are driven directly from the bench.
// ---------------------------------------------------------------------------
module tb_l1c_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_rreq;
  logic [31:0] i_addr;
  logic        i_single;
  logic [31:0] i_out;
  logic        i_wait;
  logic        d_rreq;
  logic        d_wreq;
  logic [31:0] d_addr;
  logic [31:0] d_in;
  logic [2:0]  d_type;
  logic        d_single;
  logic [31:0] d_out;
  logic        d_wait;
  logic        m_rreq;
  logic        m_wreq;
  logic [31:0] m_addr;
  logic [31:0] m_in;
  logic [2:0]  m_type;
  logic        m_single;
  logic [31:0] m_out;
  logic        m_wait;
  logic        busy_o;
  logic        owner_o;

  int n_tests;
  int n_fail;
  int n_low;

  l1c_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TYPE_W(3), .BURST_LEN(4), .D_FIRST(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .i_rreq(i_rreq), .i_addr(i_addr), .i_single(i_single),
    .i_out(i_out), .i_wait(i_wait),
    .d_rreq(d_rreq), .d_wreq(d_wreq), .d_addr(d_addr), .d_in(d_in),
    .d_type(d_type), .d_single(d_single), .d_out(d_out), .d_wait(d_wait),
    .m_rreq(m_rreq), .m_wreq(m_wreq), .m_addr(m_addr), .m_in(m_in),
    .m_type(m_type), .m_single(m_single), .m_out(m_out), .m_wait(m_wait),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic        exp_busy [0:7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        exp_own  [0:7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] exp_addr [0:7] = '{32'h0, 32'h100, 32'h0, 32'h200, 32'h0, 32'h100, 32'h0, 32'h200};

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    i_rreq   = 1'b0;
    i_addr   = 32'h0;
    i_single = 1'b0;
    d_rreq   = 1'b0;
    d_wreq   = 1'b0;
    d_addr   = 32'h0;
    d_in     = 32'h0;
    d_type   = 3'd0;
    d_single = 1'b0;
    m_out    = 32'h0;
    m_wait   = 1'b1;

    // Reset state
    #2;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_m_rreq", m_rreq, 1'b0);
    chk("rst_m_wreq", m_wreq, 1'b0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_i_wait", i_wait, 1'b1);
    chk("rst_d_wait", d_wait, 1'b1);
    chk("rst_owner", owner_o, 1'b0);
    chk("rst_m_single", m_single, 1'b0);
    step(); step();
    rst = 1'b0;

    // 1: I line fill with gaps between beats
    step();
    i_rreq = 1'b1; i_addr = 32'h0000_1234; i_single = 1'b0; m_wait = 1'b1;
    settle();
    chk("t1_req_cycle_idle", m_rreq, 1'b0);
    step(); settle();
    chk("t1_m_rreq", m_rreq, 1'b1);
    chk("t1_m_addr", m_addr, 32'h0000_1230);
    chk("t1_m_single", m_single, 1'b0);
    chk("t1_busy", busy_o, 1'b1);
    chk("t1_owner", owner_o, 1'b0);
    chk("t1_i_wait_stall", i_wait, 1'b1);
    n_low = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      m_wait = 1'b0; m_out = 32'hA0 + 32'(k);
      settle();
      if (!i_wait) n_low++;
      chk("t1_i_out", i_out, 32'hA0 + 32'(k));
      chk("t1_d_wait", d_wait, 1'b1);
      chk("t1_d_out", d_out, 32'h0);
      step();
      m_wait = 1'b1; m_out = 32'h0;
      if (k == 3) i_rreq = 1'b0;
      settle();
      if (k < 3) begin
        chk("t1_gap_busy", busy_o, 1'b1);
        chk("t1_gap_i_wait", i_wait, 1'b1);
      end else begin
        chk("t1_end_busy", busy_o, 1'b0);
        chk("t1_end_m_rreq", m_rreq, 1'b0);
        chk("t1_end_m_addr", m_addr, 32'h0);
      end
    end
    chk("t1_beats", n_low, 4);

    // 2: D single write
    step();
    d_wreq = 1'b1; d_addr = 32'h0001_0008; d_in = 32'hDEAD_BEEF; d_type = 3'd0;
    settle();
    chk("t2_idle", busy_o, 1'b0);
    step();
    m_wait = 1'b0;
    settle();
    chk("t2_m_wreq", m_wreq, 1'b1);
    chk("t2_m_rreq", m_rreq, 1'b0);
    chk("t2_m_addr", m_addr, 32'h0001_0008);
    chk("t2_m_in", m_in, 32'hDEAD_BEEF);
    chk("t2_m_type", m_type, 3'd0);
    chk("t2_m_single", m_single, 1'b1);
    chk("t2_owner", owner_o, 1'b1);
    chk("t2_d_wait", d_wait, 1'b0);
    chk("t2_i_wait", i_wait, 1'b1);
    step();
    d_wreq = 1'b0; m_wait = 1'b1;
    settle();
    chk("t2_end_busy", busy_o, 1'b0);
    chk("t2_end_m_wreq", m_wreq, 1'b0);
    chk("t2_end_d_wait", d_wait, 1'b1);
    chk("t2_end_m_in", m_in, 32'h0);

    // 6: inputs change mid-write, latched command holds
    step();
    d_wreq = 1'b1; d_addr = 32'h0000_3000; d_in = 32'h1111_2222; d_type = 3'd2;
    settle();
    step();
    d_wreq = 1'b0; d_addr = 32'hFFFF_0000; d_in = 32'h0;
    settle();
    chk("t6_m_addr0", m_addr, 32'h0000_3000);
    chk("t6_m_wreq", m_wreq, 1'b1);
    chk("t6_m_in", m_in, 32'h1111_2222);
    step(); settle();
    chk("t6_m_addr1", m_addr, 32'h0000_3000);
    step();
    m_wait = 1'b0;
    settle();
    chk("t6_m_addr_final", m_addr, 32'h0000_3000);
    chk("t6_d_wait", d_wait, 1'b0);
    step();
    m_wait = 1'b1;
    settle();
    chk("t6_end_busy", busy_o, 1'b0);
    chk("t6_end_m_addr", m_addr, 32'h0);

    // 3: both sides request continuously after reset, D wins first
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_rreq = 1'b1; i_single = 1'b1; i_addr = 32'h200;
    d_rreq = 1'b1; d_single = 1'b1; d_addr = 32'h100;
    m_wait = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c != 0) step();
      settle();
      chk("t3_busy", busy_o, exp_busy[c]);
      chk("t3_owner", owner_o, exp_own[c]);
      chk("t3_m_addr", m_addr, exp_addr[c]);
      chk("t3_m_rreq", m_rreq, exp_busy[c]);
      chk("t3_d_wait", d_wait, !(exp_busy[c] && exp_own[c]));
      chk("t3_i_wait", i_wait, !(exp_busy[c] && !exp_own[c]));
    end
    step();
    i_rreq = 1'b0; d_rreq = 1'b0;
    settle();
    chk("t3_idle_gap", busy_o, 1'b0);
    step(); settle();
    chk("t3_stays_idle", busy_o, 1'b0);

    // 4: D burst read, memory ready every cycle
    d_rreq = 1'b1; d_single = 1'b0; d_addr = 32'h2000_0044; m_wait = 1'b0; m_out = 32'h0;
    settle();
    chk("t4_idle", busy_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      m_out = 32'hB0 + 32'(k);
      if (k == 3) d_rreq = 1'b0;
      settle();
      chk("t4_busy", busy_o, 1'b1);
      chk("t4_m_addr", m_addr, 32'h2000_0040);
      chk("t4_m_type", m_type, 3'd2);
      chk("t4_m_single", m_single, 1'b0);
      chk("t4_d_wait", d_wait, 1'b0);
      chk("t4_d_out", d_out, 32'hB0 + 32'(k));
    end
    step(); settle();
    chk("t4_end_busy", busy_o, 1'b0);
    step(); settle();
    chk("t4_still_idle", busy_o, 1'b0);

    // 5: reset during beat 2 of an I burst, then a fresh burst
    i_rreq = 1'b1; i_single = 1'b0; i_addr = 32'h0000_0040; m_wait = 1'b0;
    settle();
    step();
    m_out = 32'hC0;
    settle();
    chk("t5_beat0", i_out, 32'hC0);
    step();
    m_out = 32'hC1;
    settle();
    chk("t5_beat1", i_out, 32'hC1);
    step();
    rst = 1'b1; m_out = 32'hC2;
    settle();
    chk("t5_rst_m_rreq", m_rreq, 1'b0);
    chk("t5_rst_i_wait", i_wait, 1'b1);
    chk("t5_rst_busy", busy_o, 1'b0);
    chk("t5_rst_i_out", i_out, 32'h0);
    step();
    rst = 1'b0; m_wait = 1'b1;
    settle();
    chk("t5_post_idle", busy_o, 1'b0);
    step(); settle();
    chk("t5_regrant", busy_o, 1'b1);
    chk("t5_regrant_addr", m_addr, 32'h0000_0040);
    for (int k = 0; k < 4; k++) begin
      step();
      m_wait = 1'b0; m_out = 32'hD0 + 32'(k);
      settle();
      chk("t5_fresh_busy", busy_o, 1'b1);
      chk("t5_fresh_i_wait", i_wait, 1'b0);
      chk("t5_fresh_i_out", i_out, 32'hD0 + 32'(k));
    end
    step();
    i_rreq = 1'b0; m_wait = 1'b1;
    settle();
    chk("t5_end_busy", busy_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
